jtcop_paldma: RTL and testbench

Palette DMA engine: the write-side counterpart to the colour mixer's palette RAM read port. On a CPU trigger it copies a full palette image, one 16-bit word per entry, from a shadow buffer into palette RAM. Copying happens only while vertical blank is active, so the video path never sees a half-updated palette mid-frame. It sits between the CPU's palette shadow RAM and the palette RAM's write port, and runs on the video clock domain.

---
 rtl/jtcop_paldma.sv | 125 ++++++++++++
 tb/tb_jtcop_paldma.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_paldma.sv
// jtcop_paldma -- palette DMA engine.
// Copies a full palette image (2^AW words) from the CPU shadow buffer into
// palette RAM. Words are transferred only while vertical blank is active.
// A copy may stretch over several frames: a word that is already in flight
// is always finished, and the next word waits for the next vblank.
//
// Ports:
//   clk, rst        video clock, asynchronous active-high reset
//   LVBL            vertical blank, active-low
//   trig            one-cycle copy request from CPU decode
//   buf_cs/addr     shadow-buffer read request and word address
//   buf_din/ok      shadow-buffer read data and acknowledge
//   pal_addr/dout   palette RAM write address and data
//   pal_we          palette RAM byte write enables {hi,lo}
//   busy            copy accepted and not yet finished
//   done            one-cycle pulse after the last word is written
module jtcop_paldma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          trig,
    output logic          buf_cs,
    output logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_din,
    input  logic          buf_ok,
    output logic [AW-1:0] pal_addr,
    output logic [DW-1:0] pal_dout,
    output logic [1:0]    pal_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, WAIT_VB, READ, WRITE, DONE} state_t;

    localparam logic [AW-1:0] LAST = '1;

    state_t        st;
    logic [AW-1:0] cnt;
    logic          pending;  // one extra copy requested while busy
    logic          paused;   // display became active during the current word

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= '0;
            pending  <= 1'b0;
            paused   <= 1'b0;
            buf_cs   <= 1'b0;
            buf_addr <= '0;
            pal_addr <= '0;
            pal_dout <= '0;
            pal_we   <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Any number of requests during a copy collapse into one rerun.
            if (trig && st != IDLE) pending <= 1'b1;
            case (st)
                IDLE: begin
                    if (trig) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                        st   <= WAIT_VB;
                    end
                end
                WAIT_VB: begin
                    if (!LVBL) begin
                        buf_cs   <= 1'b1;
                        buf_addr <= cnt;
                        paused   <= 1'b0;
                        st       <= READ;
                    end
                end
                READ: begin
                    if (LVBL) paused <= 1'b1;
                    // The acknowledge edge also drops the request, so the
                    // write data/address are registered and stable for pal_we.
                    if (buf_ok) begin
                        buf_cs   <= 1'b0;
                        pal_dout <= buf_din;
                        pal_addr <= cnt;
                        pal_we   <= 2'b11;
                        st       <= WRITE;
                    end
                end
                WRITE: begin
                    pal_we <= 2'b00;
                    if (cnt == LAST) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        st   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (paused || LVBL) begin
                            st <= WAIT_VB;
                        end else begin
                            buf_cs   <= 1'b1;
                            buf_addr <= cnt + 1'b1;
                            paused   <= 1'b0;
                            st       <= READ;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // A request landing exactly in this cycle is treated as
                    // pending so it is not lost on the way back to IDLE.
                    if (pending || trig) begin
                        pending <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        st      <= WAIT_VB;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcop_paldma.sv
// Scoreboard bench for jtcop_paldma. Each accepted copy pushes the full
// expected write sequence (address, data) from the buffer image; a monitor
// pops one entry per observed write. A responder models the shadow buffer
// with fixed or random latency and optional stray acknowledges.
module tb_jtcop_paldma;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, LVBL, trig, buf_cs, buf_ok, busy, done;
    logic [AW-1:0] buf_addr, pal_addr;
    logic [DW-1:0] buf_din, pal_dout;
    logic [1:0]    pal_we;

    jtcop_paldma #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .LVBL(LVBL), .trig(trig),
        .buf_cs(buf_cs), .buf_addr(buf_addr), .buf_din(buf_din), .buf_ok(buf_ok),
        .pal_addr(pal_addr), .pal_dout(pal_dout), .pal_we(pal_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [DW-1:0] mem [N];
    wr_t           exp_q [$];
    int            lat_fix = 1;
    bit            lat_rand = 1'b0, stray = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_copy();
        for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), mem[i]});
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1 trig = 1'b1;
        @(posedge clk); #1 trig = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_cs(input int addr, input int budget, input string name);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < budget) begin
            @(posedge clk); #1;
            if (buf_cs && buf_addr == AW'(addr)) found = 1'b1;
            n++;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_buf_cs"},   32'(buf_cs),   0);
        chk({tag, "_buf_addr"}, 32'(buf_addr), 0);
        chk({tag, "_pal_addr"}, 32'(pal_addr), 0);
        chk({tag, "_pal_dout"}, 32'(pal_dout), 0);
        chk({tag, "_pal_we"},   32'(pal_we),   0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_done"},     32'(done),     0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pal_we !== 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d we %0d, expected no write", pal_addr, pal_we);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(pal_addr), 32'(e.a));
                chk("wr_data", 32'(pal_dout), 32'(e.d));
                chk("wr_we",   32'(pal_we),   32'd3);
            end
        end
    end

    // Shadow-buffer responder
    int k = 0, wn = 1;
    bit was_cs = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            buf_ok = 1'b0;
            was_cs = 1'b0;
        end else if (buf_cs) begin
            if (!was_cs) begin
                k  = 1;
                wn = lat_rand ? int'($urandom_range(5, 1)) : lat_fix;
            end else begin
                k++;
            end
            if (k == wn) begin
                buf_ok  = 1'b1;
                buf_din = mem[buf_addr];
            end else begin
                buf_ok  = 1'b0;
                buf_din = DW'($urandom);
            end
            was_cs = 1'b1;
        end else begin
            buf_ok  = stray ? ($urandom_range(2, 0) == 0) : 1'b0;
            buf_din = DW'($urandom);
            was_cs  = 1'b0;
        end
    end

    initial begin
        int  t0, tf, n, d0;
        bit  seen;
        rst = 1'b1; LVBL = 1'b0; trig = 1'b0; buf_ok = 1'b0; buf_din = '0;
        #12;
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // 1: basic copy, fixed latency 1, vblank held
        for (int i = 0; i < N; i++) mem[i] = DW'(i) ^ 16'hA5A5;
        push_copy();
        @(posedge clk); #1 trig = 1'b1; t0 = cyc;
        @(posedge clk); #1 trig = 1'b0;
        chk("busy_after_trig", 32'(busy), 1);
        wait_done(1, 3000, "basic_done");
        chk("basic_latency", 32'(done_cyc - t0), 32'd2050);
        chk("basic_queue_empty", 32'(exp_q.size()), 0);
        repeat (3) @(posedge clk); #1;
        chk("basic_busy_low", 32'(busy), 0);
        chk("basic_single_done", 32'(done_cnt), 1);

        // 2: trigger during active display
        fill_random();
        LVBL = 1'b1;
        push_copy();
        pulse_trig();
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (buf_cs) seen = 1'b1;
        end
        chk("no_cs_in_display", 32'(seen), 0);
        LVBL = 1'b0; tf = cyc;
        n = 0;
        while (!buf_cs && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_cs_delay", 32'(cyc - tf), 1);
        wait_done(2, 3000, "display_done");
        chk("display_queue_empty", 32'(exp_q.size()), 0);

        // 3: pause/resume with latency 3
        lat_fix = 3;
        fill_random();
        push_copy();
        pulse_trig();
        wait_cs(300, 2000, "pause_cs300");
        LVBL = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        chk("pause_written", 32'(exp_q.size()), 32'(N - 301));
        chk("pause_no_cs", 32'(buf_cs), 0);
        chk("pause_busy", 32'(busy), 1);
        @(posedge clk); #1 LVBL = 1'b0;
        wait_done(3, 6000, "pause_done");
        chk("pause_queue_empty", 32'(exp_q.size()), 0);
        repeat (5) @(posedge clk); #2;
        chk("pause_single_done", 32'(done_cnt), 3);

        // 4: pending trigger, third trigger absorbed
        lat_fix = 1;
        fill_random();
        push_copy();
        pulse_trig();
        wait_cs(500, 2000, "pend_cs500");
        pulse_trig();
        push_copy();
        wait_cs(800, 2000, "pend_cs800");
        pulse_trig();
        wait_done(5, 6000, "pend_done");
        d0 = done_cnt;
        repeat (2500) @(posedge clk);
        #2;
        chk("pend_no_extra_done", 32'(done_cnt), 32'(d0));
        chk("pend_queue_empty", 32'(exp_q.size()), 0);
        chk("pend_busy_low", 32'(busy), 0);

        // 5: async reset mid-copy
        fill_random();
        push_copy();
        pulse_trig();
        wait_cs(700, 2000, "rst_cs700");
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("post_rst_idle_busy", 32'(busy), 0);
        chk("post_rst_idle_cs", 32'(buf_cs), 0);
        d0 = done_cnt;
        fill_random();
        push_copy();
        pulse_trig();
        wait_done(d0 + 1, 3000, "rst_fresh_done");
        chk("rst_queue_empty", 32'(exp_q.size()), 0);

        // 6: random latency with stray acknowledges
        lat_rand = 1'b1;
        stray    = 1'b1;
        d0 = done_cnt;
        fill_random();
        push_copy();
        pulse_trig();
        wait_done(d0 + 1, 8000, "rand_done");
        chk("rand_queue_empty", 32'(exp_q.size()), 0);
        repeat (20) @(posedge clk);
        #2;
        chk("rand_single_done", 32'(done_cnt), 32'(d0 + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
